// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: the IF/ID pipeline record
// and the default reset PC.
package fetch_pkg;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // History capacity of the IF/ID record; the GHR may be no wider than this.
  localparam int IF_ID_GHR_WIDTH = 8;

  // Everything ID needs to resolve the prediction made in IF.
  typedef struct packed {
    logic                       valid;
    logic [31:0]                pc;
    logic [31:0]                pc_plus4;
    logic                       pred_taken;
    logic                       btb_hit;
    logic [IF_ID_GHR_WIDTH-1:0] ghr;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_unit_ghr_reg.sv
// Global history register: shifts in the predicted direction on a BTB hit,
// and is repaired from the snapshot carried by a mispredicted instruction.
module ghr_reg
  import fetch_pkg::*;
#(
  parameter int GHR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 btb_hit,
  input  logic                 prediction,
  input  logic                 mispredict,
  input  logic                 is_jmp,
  input  logic                 br_decision,
  input  logic [GHR_WIDTH-1:0] repair_ghr,
  output logic [GHR_WIDTH-1:0] ghr
);

  logic [GHR_WIDTH-1:0] ghr_r;
  logic [GHR_WIDTH-1:0] ghr_next_s;

  // Repair wins over speculation; a jump's snapshot is pre-shift, so its real outcome is appended.
  always_comb begin
    ghr_next_s = ghr_r;
    if (mispredict) begin
      if (is_jmp) begin
        ghr_next_s = {repair_ghr[GHR_WIDTH-2:0], br_decision};
      end else begin
        ghr_next_s = repair_ghr;
      end
    end else if (!stall && btb_hit) begin
      ghr_next_s = {ghr_r[GHR_WIDTH-2:0], prediction};
    end else begin
      ghr_next_s = ghr_r;
    end
  end

  // History state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_r <= {GHR_WIDTH{1'b0}};
    end else begin
      ghr_r <= ghr_next_s;
    end
  end

  assign ghr = ghr_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator and IF/ID register. Feeds the branch
// predictor its read tag/indices from the current PC, forms the gshare PHT
// index, and forwards prediction metadata to ID.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int          BTB_INDEX_WIDTH = 6,
  parameter int          PHT_INDEX_WIDTH = 8,
  parameter int          GHR_WIDTH       = 8,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          stall_i,
  input  logic                          IF_btb_hit_i,
  input  logic                          IF_prediction_i,
  input  logic [31:0]                   IF_btb_rd_target_i,
  output logic [31:0]                   IF_pc_o,
  output logic [31-BTB_INDEX_WIDTH-2:0] IF_PC_tag_o,
  output logic [BTB_INDEX_WIDTH-1:0]    IF_btb_rd_index_o,
  output logic [PHT_INDEX_WIDTH-1:0]    IF_pht_rd_index_o,
  input  logic                          EXMEM_mispredict_i,
  input  logic [31:0]                   EXMEM_redirect_pc_i,
  input  logic                          EXMEM_is_jmp_i,
  input  logic                          EXMEM_br_decision_i,
  input  logic [GHR_WIDTH-1:0]          EXMEM_ghr_i,
  output logic                          ID_valid_o,
  output logic [31:0]                   ID_pc_o,
  output logic [31:0]                   ID_pc_plus4_o,
  output logic                          ID_pred_taken_o,
  output logic                          ID_btb_hit_o,
  output logic [GHR_WIDTH-1:0]          ID_ghr_o,
  output logic [15:0]                   mispredict_cnt_o
);

  if (GHR_WIDTH > PHT_INDEX_WIDTH) begin : g_ghr_too_wide
    $error("fetch_pc_unit: GHR_WIDTH must not exceed PHT_INDEX_WIDTH");
  end
  if (GHR_WIDTH < 2 || GHR_WIDTH > IF_ID_GHR_WIDTH) begin : g_ghr_range
    $error("fetch_pc_unit: GHR_WIDTH out of supported range");
  end

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [31:0]                pc_r;
  logic [31:0]                pc_next_s;
  logic [31:0]                pc_plus4_s;
  logic [GHR_WIDTH-1:0]       ghr_s;
  logic [PHT_INDEX_WIDTH-1:0] ghr_ext_s;
  if_id_t                     id_r;
  if_id_t                     id_next_s;
  logic [15:0]                cnt_r;
  logic [15:0]                cnt_next_s;

  // Sequential fetch address; wraps naturally at the top of the address space.
  assign pc_plus4_s = pc_r + 32'd4;

  ghr_reg #(
    .GHR_WIDTH (GHR_WIDTH)
  ) u_ghr_reg (
    .clk         (clk_i),
    .rst         (rst_i),
    .stall       (stall_i),
    .btb_hit     (IF_btb_hit_i),
    .prediction  (IF_prediction_i),
    .mispredict  (EXMEM_mispredict_i),
    .is_jmp      (EXMEM_is_jmp_i),
    .br_decision (EXMEM_br_decision_i),
    .repair_ghr  (EXMEM_ghr_i),
    .ghr         (ghr_s)
  );

  // Zero-extend history to the PHT index width for the gshare hash.
  always_comb begin
    ghr_ext_s                = {PHT_INDEX_WIDTH{1'b0}};
    ghr_ext_s[GHR_WIDTH-1:0] = ghr_s;
  end

  // Predictor read ports come straight from the PC register so the prediction is usable this cycle.
  assign IF_pc_o           = pc_r;
  assign IF_PC_tag_o       = pc_r[31:BTB_INDEX_WIDTH+2];
  assign IF_btb_rd_index_o = pc_r[BTB_INDEX_WIDTH+1:2];
  assign IF_pht_rd_index_o = pc_r[PHT_INDEX_WIDTH+1:2] ^ ghr_ext_s;

  // Next-PC select: redirect, then stall hold, then predicted target, then PC+4.
  always_comb begin
    pc_next_s = pc_plus4_s;
    if (EXMEM_mispredict_i) begin
      pc_next_s = EXMEM_redirect_pc_i;
    end else if (stall_i) begin
      pc_next_s = pc_r;
    end else if (IF_prediction_i) begin
      pc_next_s = IF_btb_rd_target_i;
    end else begin
      pc_next_s = pc_plus4_s;
    end
  end

  // PC register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  // IF/ID next value: a redirect squashes the wrong-path fetch even when stalled.
  always_comb begin
    id_next_s = id_r;
    if (EXMEM_mispredict_i) begin
      id_next_s = '0;
    end else if (stall_i) begin
      id_next_s = id_r;
    end else begin
      id_next_s.valid      = 1'b1;
      id_next_s.pc         = pc_r;
      id_next_s.pc_plus4   = pc_plus4_s;
      id_next_s.pred_taken = IF_prediction_i;
      id_next_s.btb_hit    = IF_btb_hit_i;
      id_next_s.ghr        = IF_ID_GHR_WIDTH'(ghr_s);
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_r <= '0;
    end else begin
      id_r <= id_next_s;
    end
  end

  assign ID_valid_o      = id_r.valid;
  assign ID_pc_o         = id_r.pc;
  assign ID_pc_plus4_o   = id_r.pc_plus4;
  assign ID_pred_taken_o = id_r.pred_taken;
  assign ID_btb_hit_o    = id_r.btb_hit;
  assign ID_ghr_o        = id_r.ghr[GHR_WIDTH-1:0];

  // Mispredict counter next value, saturating at all-ones.
  always_comb begin
    cnt_next_s = cnt_r;
    if (EXMEM_mispredict_i && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + 16'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Mispredict counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign mispredict_cnt_o = cnt_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural next-PC model.
module tb_fetch_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        IF_btb_hit_i;
  logic        IF_prediction_i;
  logic [31:0] IF_btb_rd_target_i;
  logic [31:0] IF_pc_o;
  logic [23:0] IF_PC_tag_o;
  logic [5:0]  IF_btb_rd_index_o;
  logic [7:0]  IF_pht_rd_index_o;
  logic        EXMEM_mispredict_i;
  logic [31:0] EXMEM_redirect_pc_i;
  logic        EXMEM_is_jmp_i;
  logic        EXMEM_br_decision_i;
  logic [7:0]  EXMEM_ghr_i;
  logic        ID_valid_o;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_pc_plus4_o;
  logic        ID_pred_taken_o;
  logic        ID_btb_hit_o;
  logic [7:0]  ID_ghr_o;
  logic [15:0] mispredict_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  int unsigned m_ghr;
  logic        m_valid;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_pc4;
  logic        m_id_pred;
  logic        m_id_hit;
  int unsigned m_id_ghr;
  int unsigned m_cnt;

  fetch_pc_unit dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .stall_i             (stall_i),
    .IF_btb_hit_i        (IF_btb_hit_i),
    .IF_prediction_i     (IF_prediction_i),
    .IF_btb_rd_target_i  (IF_btb_rd_target_i),
    .IF_pc_o             (IF_pc_o),
    .IF_PC_tag_o         (IF_PC_tag_o),
    .IF_btb_rd_index_o   (IF_btb_rd_index_o),
    .IF_pht_rd_index_o   (IF_pht_rd_index_o),
    .EXMEM_mispredict_i  (EXMEM_mispredict_i),
    .EXMEM_redirect_pc_i (EXMEM_redirect_pc_i),
    .EXMEM_is_jmp_i      (EXMEM_is_jmp_i),
    .EXMEM_br_decision_i (EXMEM_br_decision_i),
    .EXMEM_ghr_i         (EXMEM_ghr_i),
    .ID_valid_o          (ID_valid_o),
    .ID_pc_o             (ID_pc_o),
    .ID_pc_plus4_o       (ID_pc_plus4_o),
    .ID_pred_taken_o     (ID_pred_taken_o),
    .ID_btb_hit_o        (ID_btb_hit_o),
    .ID_ghr_o            (ID_ghr_o),
    .mispredict_cnt_o    (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_ghr     = 0;
    m_valid   = 1'b0;
    m_id_pc   = 32'h0;
    m_id_pc4  = 32'h0;
    m_id_pred = 1'b0;
    m_id_hit  = 1'b0;
    m_id_ghr  = 0;
    m_cnt     = 0;
  endtask

  task automatic set_idle();
    stall_i             = 1'b0;
    IF_btb_hit_i        = 1'b0;
    IF_prediction_i     = 1'b0;
    IF_btb_rd_target_i  = 32'h0;
    EXMEM_mispredict_i  = 1'b0;
    EXMEM_redirect_pc_i = 32'h0;
    EXMEM_is_jmp_i      = 1'b0;
    EXMEM_br_decision_i = 1'b0;
    EXMEM_ghr_i         = 8'h0;
  endtask

  task automatic check_all();
    check("if_pc",     IF_pc_o, m_pc);
    check("pc_tag",    32'(IF_PC_tag_o), m_pc / 256);
    check("btb_index", 32'(IF_btb_rd_index_o), (m_pc / 4) % 64);
    check("pht_index", 32'(IF_pht_rd_index_o), ((m_pc / 4) % 256) ^ m_ghr);
    check("id_valid",  32'(ID_valid_o), 32'(m_valid));
    check("id_pc",     ID_pc_o, m_id_pc);
    check("id_pc4",    ID_pc_plus4_o, m_id_pc4);
    check("id_pred",   32'(ID_pred_taken_o), 32'(m_id_pred));
    check("id_hit",    32'(ID_btb_hit_o), 32'(m_id_hit));
    check("id_ghr",    32'(ID_ghr_o), m_id_ghr);
    check("mp_cnt",    32'(mispredict_cnt_o), m_cnt);
  endtask

  // One clock: predict everything from the inputs the DUT sees at this edge.
  task automatic step(input bit do_check);
    logic [31:0] n_pc;
    int unsigned n_ghr;
    if (EXMEM_mispredict_i)   n_pc = EXMEM_redirect_pc_i;
    else if (stall_i)         n_pc = m_pc;
    else if (IF_prediction_i) n_pc = IF_btb_rd_target_i;
    else                      n_pc = m_pc + 32'd4;
    if (EXMEM_mispredict_i)
      n_ghr = EXMEM_is_jmp_i ? (EXMEM_ghr_i * 2 + EXMEM_br_decision_i) % 256 : EXMEM_ghr_i;
    else if (!stall_i && IF_btb_hit_i)
      n_ghr = (m_ghr * 2 + IF_prediction_i) % 256;
    else
      n_ghr = m_ghr;
    @(posedge clk_i);
    #1;
    if (EXMEM_mispredict_i) begin
      m_valid = 1'b0; m_id_pc = 32'h0; m_id_pc4 = 32'h0;
      m_id_pred = 1'b0; m_id_hit = 1'b0; m_id_ghr = 0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else if (!stall_i) begin
      m_valid = 1'b1; m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4;
      m_id_pred = IF_prediction_i; m_id_hit = IF_btb_hit_i; m_id_ghr = m_ghr;
    end
    m_pc  = n_pc;
    m_ghr = n_ghr;
    if (do_check) check_all();
  endtask

  initial begin
    int guard;
    rst_i = 1'b1;
    set_idle();
    model_reset();
    #2;
    check_all();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_all();
    check("first_id_valid", 32'(ID_valid_o), 32'd0);

    // Sequential fetch up to 0x20
    guard = 0;
    while (m_pc != 32'h20 && guard < 100) begin step(1'b1); guard++; end
    check("reach_20", IF_pc_o, 32'h20);
    check("id_trails", ID_pc_o, 32'h1C);

    // Three-cycle stall at 0x20
    stall_i = 1'b1;
    IF_btb_hit_i = 1'b1;
    IF_prediction_i = 1'b1;
    IF_btb_rd_target_i = 32'h300;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      check("stall_pc", IF_pc_o, 32'h20);
      check("stall_id", ID_pc_o, 32'h1C);
    end
    set_idle();
    step(1'b1);
    check("stall_resume", IF_pc_o, 32'h24);

    // Predicted-taken branch at 0x40
    guard = 0;
    while (m_pc != 32'h40 && guard < 100) begin step(1'b1); guard++; end
    IF_btb_hit_i = 1'b1;
    IF_prediction_i = 1'b1;
    IF_btb_rd_target_i = 32'h100;
    step(1'b1);
    set_idle();
    check("taken_pc", IF_pc_o, 32'h100);
    check("taken_id_pred", 32'(ID_pred_taken_o), 32'd1);
    check("taken_pht", 32'(IF_pht_rd_index_o), 32'h41);
    step(1'b1);
    check("taken_ghr_lsb", 32'(ID_ghr_o), 32'h01);

    // Mispredict together with stall
    stall_i = 1'b1;
    EXMEM_mispredict_i = 1'b1;
    EXMEM_redirect_pc_i = 32'h200;
    EXMEM_ghr_i = 8'h5A;
    EXMEM_is_jmp_i = 1'b1;
    EXMEM_br_decision_i = 1'b1;
    step(1'b1);
    set_idle();
    check("mp_pc", IF_pc_o, 32'h200);
    check("mp_bubble", 32'(ID_valid_o), 32'd0);
    check("mp_ghr_pht", 32'(IF_pht_rd_index_o), 32'h35);
    step(1'b1);
    check("mp_ghr", 32'(ID_ghr_o), 32'hB5);

    // Wrap at top of address space
    EXMEM_mispredict_i = 1'b1;
    EXMEM_redirect_pc_i = 32'hFFFF_FFFC;
    EXMEM_ghr_i = 8'hFF;
    step(1'b1);
    set_idle();
    check("wrap_top", IF_pc_o, 32'hFFFF_FFFC);
    step(1'b1);
    check("wrap_zero", IF_pc_o, 32'h0);
    step(1'b1);
    check("wrap_pht", 32'(IF_pht_rd_index_o), 32'hFE);

    // Counter to five, then asynchronous reset mid-cycle
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      EXMEM_mispredict_i = 1'b1;
      EXMEM_redirect_pc_i = 32'h1000 + 32'(i * 16);
      step(1'b1);
    end
    set_idle();
    step(1'b1);
    check("cnt_five", 32'(mispredict_cnt_o), 32'd5);
    #3;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async_rst_cnt", 32'(mispredict_cnt_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check("first_fetch", IF_pc_o, 32'h0);
    step(1'b1);
    check("after_rst_id", ID_pc_o, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      IF_btb_hit_i        = ($urandom_range(0, 2) == 0);
      IF_prediction_i     = IF_btb_hit_i & 1'($urandom_range(0, 1));
      IF_btb_rd_target_i  = $urandom;
      stall_i             = ($urandom_range(0, 5) == 0);
      EXMEM_mispredict_i  = ($urandom_range(0, 9) == 0);
      EXMEM_redirect_pc_i = $urandom;
      EXMEM_is_jmp_i      = 1'($urandom_range(0, 1));
      EXMEM_br_decision_i = 1'($urandom_range(0, 1));
      EXMEM_ghr_i         = 8'($urandom);
      step(1'b1);
    end

    // Counter saturation
    EXMEM_mispredict_i = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      EXMEM_redirect_pc_i = $urandom;
      step(1'b0);
    end
    check_all();
    check("cnt_sat", 32'(mispredict_cnt_o), 32'h0000_FFFF);
    step(1'b1);
    check("cnt_sat_hold", 32'(mispredict_cnt_o), 32'h0000_FFFF);
    set_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
